// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave frame receiver.
package spi_pkg;

  localparam int FRAME_BITS = 16;
  localparam int SPI_MODE   = 0;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE
  } spi_rx_state_t;

  typedef logic [FRAME_BITS-1:0] frame_t;

endpackage

// File: rtl/spi_slave_frame_rx_sync_ff.sv
// Multi-stage flop chain bringing an asynchronous pin into the clk domain.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_slave_frame_rx.sv
// SPI mode-0 slave that receives a 16-bit MSB-first frame and presents its
// low DATA_WIDTH bits to the display controller with a one-cycle strobe.
//
// state | meaning
// IDLE  | SS inactive or frame finished; sclk edges ignored
// RECV  | SS active, shifting in bits on each sclk rise
// DONE  | 16 bits received; waiting for SS release, extra edges ignored
module spi_slave_frame_rx
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 14,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_sclk,
  input  logic                  i_mosi,
  input  logic                  i_ss,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_frame_err,
  output logic                  o_busy
);

  if (DATA_WIDTH < 9 || DATA_WIDTH > FRAME_BITS) begin : g_bad_width
    $error("spi_slave_frame_rx: DATA_WIDTH must be within 9..16");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("spi_slave_frame_rx: SYNC_STAGES must be at least 2");
  end

  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

  logic          sclk_sync;
  logic          mosi_sync;
  logic          ss_sync;
  logic          sclk_prev;
  logic          sclk_rise;
  spi_rx_state_t state;
  frame_t        shift;
  frame_t        shift_next;
  logic [4:0]    bit_cnt;

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .d(i_sclk), .q(sclk_sync)
  );

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .d(i_mosi), .q(mosi_sync)
  );

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk(clk), .reset(reset), .d(i_ss), .q(ss_sync)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_prev <= 1'b0;
    end else begin
      sclk_prev <= sclk_sync;
    end
  end

  assign sclk_rise  = sclk_sync & ~sclk_prev;
  assign shift_next = {shift[FRAME_BITS-2:0], mosi_sync};

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= 5'd0;
      shift       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!ss_sync) begin
            state   <= RECV;
            bit_cnt <= 5'd0;
            shift   <= '0;
            o_busy  <= 1'b1;
          end
        end
        RECV: begin
          // SS release takes priority over a coincident sclk edge
          if (ss_sync) begin
            state       <= IDLE;
            o_frame_err <= (bit_cnt != 5'd0);
            bit_cnt     <= 5'd0;
            shift       <= '0;
            o_busy      <= 1'b0;
          end else if (sclk_rise) begin
            shift   <= shift_next;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == LAST_BIT) begin
              state   <= DONE;
              o_data  <= shift_next[DATA_WIDTH-1:0];
              o_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (ss_sync) begin
            state   <= IDLE;
            bit_cnt <= 5'd0;
            shift   <= '0;
            o_busy  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= 5'd0;
          shift   <= '0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
